// File: rtl/cam_ctrl_pkg.sv
// cam_ctrl_pkg: shared types and constants for the CAM sequencer/arbiter.
// Optional feature macro used by this slice: CAM_CTRL_RR_EN (round-robin arbitration).
package cam_ctrl_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int SIZE_ADDR_DEF = 4;

    localparam logic OP_LOOKUP = 1'b0;
    localparam logic OP_INSERT = 1'b1;

    // Cleared CAM entries read as 0x00, so that key can never be stored or searched.
    localparam logic [7:0] RESERVED_KEY = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_CHECK  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/cam_req_arbiter.sv
// cam_req_arbiter: picks one requester while the sequencer is idle.
// CAM_CTRL_RR_EN defined   -> round-robin, pointer moves past the last grant.
// CAM_CTRL_RR_EN undefined -> fixed priority, lowest index wins (pointer pinned at 0).
module cam_req_arbiter
    import cam_ctrl_pkg::*;
#(
    parameter int NB_REQ = 2,
    parameter int ID_W   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NB_REQ-1:0] req_valid,
    input  logic              grant_en,
    output logic [NB_REQ-1:0] grant,
    output logic [ID_W-1:0]   grant_id
);

    logic [ID_W-1:0] prio_ptr;
    logic [ID_W-1:0] prio_ptr_n;
    logic            any_grant;

    // Choose the valid requester closest to the priority pointer, then one-hot encode it.
    always_comb begin
        int best_rank;
        int rank;
        best_rank = NB_REQ;
        rank      = 0;
        grant_id  = '0;
        grant     = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (i >= int'(prio_ptr)) rank = i - int'(prio_ptr);
            else                     rank = i + NB_REQ - int'(prio_ptr);
            if (grant_en && req_valid[i] && (rank < best_rank)) begin
                best_rank = rank;
                grant_id  = ID_W'(i);
            end
        end
        any_grant = (best_rank < NB_REQ);
        for (int i = 0; i < NB_REQ; i++) begin
            grant[i] = any_grant && (grant_id == ID_W'(i));
        end
    end

`ifdef CAM_CTRL_RR_EN
    // Next pointer is one past the granted requester, wrapping at NB_REQ.
    always_comb begin
        prio_ptr_n = prio_ptr;
        if (any_grant) begin
            if (int'(grant_id) == NB_REQ - 1) prio_ptr_n = '0;
            else                              prio_ptr_n = grant_id + 1'b1;
        end
    end
`else
    // Fixed priority: the search always starts at requester 0.
    always_comb begin
        prio_ptr_n = '0;
    end
`endif

    // Priority pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_ptr <= '0;
        else        prio_ptr <= prio_ptr_n;
    end

endmodule

// File: rtl/cam_ctrl.sv
// cam_ctrl: serialises lookup/insert requests onto one CAM, owns linear slot
// allocation and returns a one-cycle response to the granted requester.
// Optional feature macro: CAM_CTRL_RR_EN (round-robin arbitration in cam_req_arbiter).
module cam_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int NB_REQ    = 2,
    parameter int NB_MEM    = 16,
    parameter int SIZE_ADDR = SIZE_ADDR_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NB_REQ-1:0]        req_valid,
    input  logic [NB_REQ-1:0]        req_op,
    input  logic [NB_REQ*DATA_W-1:0] req_data,
    output logic [NB_REQ-1:0]        req_ready,
    output logic [NB_REQ-1:0]        rsp_valid,
    output logic                     rsp_hit,
    output logic                     rsp_err,
    output logic [SIZE_ADDR:0]       rsp_idx,
    output logic                     cam_enable,
    output logic                     cam_write,
    output logic [SIZE_ADDR:0]       cam_addr,
    output logic [DATA_W-1:0]        cam_data,
    input  logic [SIZE_ADDR:0]       cam_out,
    input  logic                     cam_found,
    output logic                     full,
    output logic [SIZE_ADDR:0]       count
);

    localparam int              ID_W     = (NB_REQ > 2) ? 2 : 1;
    localparam logic [SIZE_ADDR:0]   MEM_FULL = (SIZE_ADDR+1)'(NB_MEM);
    localparam logic [SIZE_ADDR-1:0] LAST_PTR = SIZE_ADDR'(NB_MEM - 1);

    state_t                 state;
    state_t                 state_n;
    logic                   grant_en;
    logic [NB_REQ-1:0]      grant;
    logic [ID_W-1:0]        gnt_id;
    logic [DATA_W-1:0]      sel_key;
    logic                   sel_op;
    logic                   sel_rsvd;
    logic [ID_W-1:0]        id_r;
    logic                   op_r;
    logic [DATA_W-1:0]      key_r;
    logic                   hit_r;
    logic                   err_r;
    logic [SIZE_ADDR:0]     idx_r;
    logic [SIZE_ADDR-1:0]   alloc_ptr;

    assign grant_en  = (state == ST_IDLE);
    assign req_ready = grant;
    assign full      = (count == MEM_FULL);
    assign sel_rsvd  = (sel_key == DATA_W'(RESERVED_KEY));

    cam_req_arbiter #(
        .NB_REQ (NB_REQ),
        .ID_W   (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .grant_en  (grant_en),
        .grant     (grant),
        .grant_id  (gnt_id)
    );

    // Route the granted requester's op and key to the latch stage.
    always_comb begin
        sel_key = '0;
        sel_op  = OP_LOOKUP;
        for (int i = 0; i < NB_REQ; i++) begin
            if (grant[i]) begin
                sel_key = req_data[i*DATA_W +: DATA_W];
                sel_op  = req_op[i];
            end
        end
    end

    // Control state: FSM state, fill pointer and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            alloc_ptr <= '0;
            count     <= '0;
        end else begin
            state <= state_n;
            if (state == ST_WRITE) begin
                if (alloc_ptr != LAST_PTR) alloc_ptr <= alloc_ptr + 1'b1;
                if (!full)                 count     <= count + 1'b1;
            end
        end
    end

    // Transaction context and response fields; meaningful only while a transaction is open.
    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    id_r  <= gnt_id;
                    op_r  <= sel_op;
                    key_r <= sel_key;
                    hit_r <= 1'b0;
                    err_r <= sel_rsvd;
                    idx_r <= '0;
                end
            end
            ST_CHECK: begin
                hit_r <= cam_found;
                err_r <= (op_r == OP_INSERT) && !cam_found && full;
                idx_r <= cam_found ? cam_out : '0;
            end
            ST_WRITE: begin
                hit_r <= 1'b0;
                err_r <= 1'b0;
                idx_r <= {1'b0, alloc_ptr};
            end
            default: ;
        endcase
    end

    // Next-state decode and all CAM/response pin values for the current state.
    always_comb begin
        state_n    = state;
        cam_enable = 1'b0;
        cam_write  = 1'b0;
        cam_addr   = '0;
        cam_data   = '0;
        rsp_valid  = '0;
        rsp_hit    = 1'b0;
        rsp_err    = 1'b0;
        rsp_idx    = '0;
        case (state)
            ST_IDLE: begin
                if (|grant) state_n = sel_rsvd ? ST_RESP : ST_SEARCH;
            end
            ST_SEARCH: begin
                cam_enable = 1'b1;
                cam_data   = key_r;
                state_n    = ST_CHECK;
            end
            ST_CHECK: begin
                if ((op_r == OP_LOOKUP) || cam_found || full) state_n = ST_RESP;
                else                                          state_n = ST_WRITE;
            end
            ST_WRITE: begin
                cam_write = 1'b1;
                cam_addr  = {1'b0, alloc_ptr};
                cam_data  = key_r;
                state_n   = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = NB_REQ'(1) << id_r;
                rsp_hit   = hit_r;
                rsp_err   = err_r;
                rsp_idx   = idx_r;
                state_n   = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: randomized and directed stimulus for cam_ctrl with a transaction-level
// reference model and a behavioural registered CAM attached to the CAM pins.
module tb_cam_ctrl;

    localparam int NB_REQ    = 2;
    localparam int NB_MEM    = 16;
    localparam int SIZE_ADDR = 4;
    localparam int DATA_W    = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic [NB_REQ-1:0]        req_valid;
    logic [NB_REQ-1:0]        req_op;
    logic [NB_REQ*DATA_W-1:0] req_data;
    logic [NB_REQ-1:0]        req_ready;
    logic [NB_REQ-1:0]        rsp_valid;
    logic                     rsp_hit;
    logic                     rsp_err;
    logic [SIZE_ADDR:0]       rsp_idx;
    logic                     cam_enable;
    logic                     cam_write;
    logic [SIZE_ADDR:0]       cam_addr;
    logic [DATA_W-1:0]        cam_data;
    logic [SIZE_ADDR:0]       cam_out;
    logic                     cam_found;
    logic                     full;
    logic [SIZE_ADDR:0]       count;

    // requester-side drive state
    bit              vld_a [NB_REQ];
    bit              op_a  [NB_REQ];
    logic [7:0]      key_a [NB_REQ];

    assign req_valid = {vld_a[1], vld_a[0]};
    assign req_op    = {op_a[1], op_a[0]};
    assign req_data  = {key_a[1], key_a[0]};

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cam_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_err    (rsp_err),
        .rsp_idx    (rsp_idx),
        .cam_enable (cam_enable),
        .cam_write  (cam_write),
        .cam_addr   (cam_addr),
        .cam_data   (cam_data),
        .cam_out    (cam_out),
        .cam_found  (cam_found),
        .full       (full),
        .count      (count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural CAM: registered search result, lowest matching slot wins.
    logic [DATA_W-1:0] cam_mem [NB_MEM];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB_MEM; i++) cam_mem[i] <= '0;
            cam_found <= 1'b0;
            cam_out   <= '0;
        end else begin
            if (cam_write) cam_mem[cam_addr[SIZE_ADDR-1:0]] <= cam_data;
            if (cam_enable) begin
                cam_found <= 1'b0;
                cam_out   <= '0;
                for (int i = NB_MEM - 1; i >= 0; i--) begin
                    if (cam_mem[i] == cam_data) begin
                        cam_found <= 1'b1;
                        cam_out   <= 5'(i);
                    end
                end
            end
        end
    end

    // Reference model: list of stored keys plus one open transaction timeline.
    logic [7:0] m_keys[$];
    int   m_busy = 0, m_t = 0, m_id = 0, m_resp_t = 0, m_idx = 0, m_wr_addr = 0, m_ptr = 0;
    bit   m_hit, m_err, m_wr, m_rsvd;
    logic [7:0] m_key;

    always @(negedge clk) begin : cmp_proc
        int g, f, e_ready, e_en, e_wr, e_addr, e_data, e_rv, e_hit, e_err, e_idx;
        if (!rst_n) begin
            m_keys.delete();
            m_busy = 0;
            m_ptr  = 0;
            chk("reset_outs", int'({req_ready, rsp_valid, rsp_hit, rsp_err, rsp_idx, cam_enable,
                                    cam_write, cam_addr, cam_data, full, count}), 0);
        end else begin
            g = -1; e_ready = 0; e_en = 0; e_wr = 0; e_addr = 0; e_data = 0;
            e_rv = 0; e_hit = 0; e_err = 0; e_idx = 0;
            if (m_busy != 0) begin
                m_t++;
                if (m_t == 1 && !m_rsvd) begin e_en = 1; e_data = m_key; end
                if (m_t == 3 && m_wr) begin e_wr = 1; e_addr = m_wr_addr; e_data = m_key; end
                if (m_t == m_resp_t) begin
                    e_rv = 1 << m_id; e_hit = m_hit; e_err = m_err; e_idx = m_idx;
                end
            end else begin
                for (int k = 0; k < NB_REQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NB_REQ;
                    if (g < 0 && vld_a[j]) g = j;
                end
                if (g >= 0) e_ready = 1 << g;
            end
            chk("req_ready",  req_ready,  e_ready);
            chk("cam_enable", cam_enable, e_en);
            chk("cam_write",  cam_write,  e_wr);
            chk("cam_addr",   cam_addr,   e_addr);
            chk("cam_data",   cam_data,   e_data);
            chk("rsp_valid",  rsp_valid,  e_rv);
            chk("rsp_hit",    rsp_hit,    e_hit);
            chk("rsp_err",    rsp_err,    e_err);
            chk("rsp_idx",    rsp_idx,    e_idx);
            chk("count",      count,      m_keys.size());
            chk("full",       full,       (m_keys.size() == NB_MEM) ? 1 : 0);
            if (m_busy != 0) begin
                if (m_t == 3 && m_wr) m_keys.push_back(m_key);
                if (m_t == m_resp_t) m_busy = 0;
            end else if (g >= 0) begin
                m_busy = 1; m_t = 0; m_id = g; m_key = key_a[g];
                m_hit = 0; m_err = 0; m_wr = 0; m_idx = 0; m_rsvd = 0; m_resp_t = 3;
                if (m_key == 8'h00) begin
                    m_rsvd = 1; m_err = 1; m_resp_t = 1;
                end else begin
                    f = -1;
                    for (int i = 0; i < m_keys.size(); i++) if (f < 0 && m_keys[i] == m_key) f = i;
                    if (f >= 0) begin
                        m_hit = 1; m_idx = f;
                    end else if (op_a[g]) begin
                        if (m_keys.size() == NB_MEM) m_err = 1;
                        else begin
                            m_wr = 1; m_wr_addr = m_keys.size(); m_idx = m_keys.size(); m_resp_t = 4;
                        end
                    end
                end
`ifdef CAM_CTRL_RR_EN
                m_ptr = (g + 1) % NB_REQ;
`endif
            end
        end
    end

    // Issue one request from requester r and report latency (cycles after accept) and response.
    task automatic do_req(input int r, input bit op, input logic [7:0] key,
                          output int lat, output int hit, output int err, output int idx);
        bit got;
        lat = -1; hit = 0; err = 0; idx = 0; got = 0;
        @(posedge clk); #1;
        op_a[r] = op; key_a[r] = key; vld_a[r] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (((req_ready >> r) & 2'b01) != 0) begin got = 1; break; end
        end
        @(posedge clk); #1;
        vld_a[r] = 1'b0;
        if (!got) begin chk("accept_timeout", 0, 1); return; end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (((rsp_valid >> r) & 2'b01) != 0) begin
                lat = k; hit = rsp_hit; err = rsp_err; idx = rsp_idx; break;
            end
        end
        if (lat < 0) chk("rsp_timeout", 0, 1);
    endtask

    task automatic do_reset();
        vld_a[0] = 0; vld_a[1] = 0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin : main
        int lat, hit, err, idx;
        int seq [4];
        int ng;
        logic [NB_REQ-1:0] acc;
        logic [7:0] rkey;
        int sel;
        for (int i = 0; i < NB_REQ; i++) begin vld_a[i] = 0; op_a[i] = 0; key_a[i] = 8'h00; end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;

        // first insert after reset
        do_req(0, 1'b1, 8'h3C, lat, hit, err, idx);
        chk("ins3c_lat", lat, 4); chk("ins3c_hit", hit, 0); chk("ins3c_err", err, 0); chk("ins3c_idx", idx, 0);
        chk("ins3c_count", count, 1);
        do_req(0, 1'b1, 8'h3C, lat, hit, err, idx);
        chk("reins_lat", lat, 3); chk("reins_hit", hit, 1); chk("reins_idx", idx, 0);
        do_req(1, 1'b0, 8'h3C, lat, hit, err, idx);
        chk("look3c_lat", lat, 3); chk("look3c_hit", hit, 1); chk("look3c_idx", idx, 0);
        chk("look3c_count", count, 1);

        // reserved key
        do_req(1, 1'b0, 8'h00, lat, hit, err, idx);
        chk("rsvd_look_lat", lat, 1); chk("rsvd_look_err", err, 1);
        do_req(0, 1'b1, 8'h00, lat, hit, err, idx);
        chk("rsvd_ins_lat", lat, 1); chk("rsvd_ins_err", err, 1); chk("rsvd_ins_hit", hit, 0);

        // reset during WRITE aborts the insert
        @(posedge clk); #1;
        op_a[0] = 1'b1; key_a[0] = 8'h77; vld_a[0] = 1'b1;
        ng = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[0]) begin ng = 1; break; end
        end
        chk("abort_accept", ng, 1);
        @(posedge clk); #1 vld_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_wr", cam_write, 1); chk("abort_addr", cam_addr, 1);
        #2 rst_n = 1'b0;
        repeat (2) begin @(negedge clk); chk("abort_norsp", rsp_valid, 0); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_count", count, 0);
        do_req(0, 1'b0, 8'h77, lat, hit, err, idx);
        chk("abort_look_lat", lat, 3); chk("abort_look_hit", hit, 0); chk("abort_look_idx", idx, 0);

        // fill all slots, then overflow
        do_reset();
        for (int i = 0; i < NB_MEM; i++) begin
            do_req(i % 2, 1'b1, 8'(8'h40 + i), lat, hit, err, idx);
            chk($sformatf("fill%0d_idx", i), idx, i);
            chk($sformatf("fill%0d_lat", i), lat, 4);
        end
        chk("fill_full", full, 1); chk("fill_count", count, 16);
        do_req(0, 1'b1, 8'h99, lat, hit, err, idx);
        chk("ovf_lat", lat, 3); chk("ovf_err", err, 1); chk("ovf_idx", idx, 0); chk("ovf_count", count, 16);
        do_req(1, 1'b1, 8'h45, lat, hit, err, idx);
        chk("full_reins_hit", hit, 1); chk("full_reins_idx", idx, 5); chk("full_reins_err", err, 0);

        // both requesters held together
        do_reset();
        @(posedge clk); #1;
        op_a[0] = 0; op_a[1] = 0; key_a[0] = 8'h11; key_a[1] = 8'h22;
        vld_a[0] = 1; vld_a[1] = 1;
        ng = 0;
        for (int c = 0; c < 80 && ng < 4; c++) begin
            @(negedge clk);
            if (req_ready != 0) begin seq[ng] = req_ready[1] ? 1 : 0; ng++; end
        end
        @(posedge clk); #1 vld_a[0] = 0; vld_a[1] = 0;
        repeat (6) @(posedge clk);
        chk("arb_grants", ng, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef CAM_CTRL_RR_EN
            chk($sformatf("arb_grant%0d", i), seq[i], i % 2);
`else
            chk($sformatf("arb_grant%0d", i), seq[i], 0);
`endif
        end

        // randomized traffic with cancellations
        do_reset();
        acc = '0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int r = 0; r < NB_REQ; r++) begin
                if (vld_a[r] && acc[r]) vld_a[r] = 0;
                else if (vld_a[r]) begin
                    if ($urandom_range(0, 24) == 0) vld_a[r] = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    sel = $urandom_range(0, 20);
                    rkey = (sel == 0) ? 8'h00 : 8'(8'h80 + sel);
                    key_a[r] = rkey;
                    op_a[r] = ($urandom_range(0, 2) != 0);
                    vld_a[r] = 1;
                end
            end
            @(negedge clk);
            acc = req_ready;
        end
        @(posedge clk); #1 vld_a[0] = 0; vld_a[1] = 0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cam_ctrl.md
# cam_ctrl

Sequencer and arbiter that shares one 16-entry, 8-bit content-addressable memory between NB_REQ requesters. Each request is a lookup or an insert. The block serialises requests and drives the CAM's enable/write/addr/data pins. It owns slot allocation (a linear fill pointer and an occupancy count) and returns a one-cycle response with hit, error and index to the granted requester. It sits directly in front of the cam instance, on the same clk and rst_n.

## Interface
- NB_REQ, 2, number of requesters (2..4)
- NB_MEM, 16, CAM depth; must equal the CAM's depth
- SIZE_ADDR, 4, log2(NB_MEM)
- DATA_W, 8, key width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NB_REQ  per-requester request; held until accepted
- req_op  in  NB_REQ  per-requester op: 0 = lookup, 1 = insert
- req_data  in  NB_REQ*DATA_W  per-requester key; requester i uses bits [i*DATA_W +: DATA_W]
- req_ready  out  NB_REQ  one-hot acceptance pulse
- rsp_valid  out  NB_REQ  one-hot one-cycle response strobe
- rsp_hit  out  1  key present in CAM; valid with rsp_valid
- rsp_err  out  1  reserved key (0x00), or insert miss while full
- rsp_idx  out  SIZE_ADDR+1  slot index, MSB always 0
- cam_enable  out  1  CAM search strobe
- cam_write  out  1  CAM write strobe
- cam_addr  out  SIZE_ADDR+1  CAM write address, MSB always 0
- cam_data  out  DATA_W  CAM key
- cam_out  in  SIZE_ADDR+1  CAM match index, registered
- cam_found  in  1  CAM match flag, registered
- full  out  1  count == NB_MEM
- count  out  SIZE_ADDR+1  number of occupied slots

## Operation
- States: IDLE, SEARCH, CHECK, WRITE, RESP.
- IDLE
  - If any req_valid is high: grant one requester, pulse its req_ready, and latch requester id, op and key.
  - Key 0x00 goes to RESP with err=1; it is reserved because cleared CAM entries are 0x00.
  - Any other key goes to SEARCH.
- SEARCH: cam_enable=1 and cam_data=key for exactly one cycle; go to CHECK.
- CHECK: sample cam_found and cam_out, then branch:
  - Lookup: go to RESP with hit=cam_found, idx=cam_out (idx=0 on miss).
  - Insert hit: go to RESP with hit=1, idx=cam_out; no write.
  - Insert miss while full: go to RESP with err=1, idx=0.
  - Insert miss otherwise: go to WRITE.
- WRITE
  - cam_write=1, cam_addr=alloc_ptr, cam_data=key.
  - Response carries idx=alloc_ptr, hit=0.
  - alloc_ptr and count each increment by 1.
  - Go to RESP.
- RESP: rsp_valid[id]=1 for one cycle with hit/err/idx; go to IDLE.
- alloc_ptr is SIZE_ADDR bits. It advances only on a write and stops at NB_MEM-1; further writes are blocked by full, so it never wraps.
- count saturates at NB_MEM. There is no delete operation.
- cam_enable and cam_write are never high in the same cycle. In IDLE, CHECK and RESP all CAM strobes are 0 and cam_data/cam_addr are 0.
- rsp_hit, rsp_err and rsp_idx are 0 whenever rsp_valid is 0.
- Requests arriving while the block is busy wait, with req_valid held. Dropping req_valid before req_ready is legal and cancels the request.

## Timing
- Request accepted at cycle 0, the IDLE cycle with req_ready.
- Lookup, or insert hit/full: SEARCH at cycle 1, CHECK at 2, rsp_valid at cycle 3.
- Insert miss: WRITE at cycle 3, rsp_valid at cycle 4.
- Reserved key: rsp_valid at cycle 1.
- Next grant is possible in the cycle after RESP. Peak throughput is one lookup per 4 cycles.
- Reset values:
  - All outputs are 0, state is IDLE, alloc_ptr=0, count=0.
  - Asserting rst_n mid-operation aborts the transaction with no response.
  - The CAM shares rst_n and clears at the same time.

## Configuration
- CAM_CTRL_RR_EN defined: round-robin arbitration.
  - The priority pointer moves to (granted id + 1) mod NB_REQ after each grant.
  - With every requester continuously requesting, each is granted once per NB_REQ grants.
- CAM_CTRL_RR_EN undefined: fixed priority; the lowest requester index wins.

## Structure
- Package cam_ctrl_pkg:
  - state enum
  - OP_LOOKUP/OP_INSERT constants
  - RESERVED_KEY = 8'h00
  - DATA_W/SIZE_ADDR defaults
- Sub-module cam_req_arbiter:
  - Inputs: req_valid and grant_en (high in IDLE).
  - Outputs: one-hot grant and encoded id.
  - Contains the CAM_CTRL_RR_EN logic and its priority pointer.

## Test plan
- Reset, then insert 0x3C from req0: rsp_valid[0] at cycle 4, hit=0, idx=0, count=1, one cam_write at addr 0.
- Insert 0x3C again, then lookup 0x3C: both responses hit=1, idx=0, no cam_write, count remains 1.
- Lookup 0x00 or insert 0x00: rsp_valid at cycle 1, err=1, cam_enable never asserted.
- Fill 16 distinct keys, then insert a 17th new key: rsp_err=1, full=1, count=16, no write. Reinserting an existing key still returns hit=1 and its idx.
- req0 and req1 asserted together and held, RR_EN defined: grants alternate 0,1,0,1. Without RR_EN: req0 is granted repeatedly until it drops req_valid.
- rst_n pulsed during WRITE: no rsp_valid, count=0, and a following lookup of the aborted key misses.
